// File: rtl/sfx_sequencer_pkg.sv
// Shared definitions for the sound-effect sequencer: effect codes (code doubles
// as priority), FSM states, counter widths and the melody tables.
package sfx_sequencer_pkg;

    typedef enum logic [1:0] {
        SFX_NONE      = 2'd0,
        SFX_JUMP      = 2'd1,
        SFX_MILESTONE = 2'd2,
        SFX_GAMEOVER  = 2'd3
    } sfx_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam int HALF_W = 16;
    localparam int TICK_W = 5;
    localparam int NOTE_W = 3;

    // Number of notes in each effect's melody.
    function automatic logic [NOTE_W-1:0] note_count(input sfx_e s);
        case (s)
            SFX_JUMP:      note_count = 3'd2;
            SFX_MILESTONE: note_count = 3'd3;
            SFX_GAMEOVER:  note_count = 3'd5;
            default:       note_count = 3'd0;
        endcase
    endfunction

    // Half-period in clocks of a note; 0 marks a rest.
    function automatic logic [HALF_W-1:0] note_half(input sfx_e s, input logic [NOTE_W-1:0] idx);
        note_half = 16'd0;
        case (s)
            SFX_JUMP: begin
                case (idx)
                    3'd0:    note_half = 16'd14304;
                    3'd1:    note_half = 16'd9536;
                    default: note_half = 16'd0;
                endcase
            end
            SFX_MILESTONE: begin
                case (idx)
                    3'd0:    note_half = 16'd12022;
                    3'd1:    note_half = 16'd9543;
                    3'd2:    note_half = 16'd8028;
                    default: note_half = 16'd0;
                endcase
            end
            SFX_GAMEOVER: begin
                case (idx)
                    3'd0:    note_half = 16'd16056;
                    3'd1:    note_half = 16'd21444;
                    3'd2:    note_half = 16'd32111;
                    3'd3:    note_half = 16'd0;
                    3'd4:    note_half = 16'd64222;
                    default: note_half = 16'd0;
                endcase
            end
            default: note_half = 16'd0;
        endcase
    endfunction

    // Note length in game ticks.
    function automatic logic [TICK_W-1:0] note_dur(input sfx_e s, input logic [NOTE_W-1:0] idx);
        note_dur = 5'd0;
        case (s)
            SFX_JUMP: begin
                case (idx)
                    3'd0, 3'd1: note_dur = 5'd3;
                    default:    note_dur = 5'd0;
                endcase
            end
            SFX_MILESTONE: begin
                case (idx)
                    3'd0, 3'd1: note_dur = 5'd4;
                    3'd2:       note_dur = 5'd6;
                    default:    note_dur = 5'd0;
                endcase
            end
            SFX_GAMEOVER: begin
                case (idx)
                    3'd0, 3'd1, 3'd2: note_dur = 5'd8;
                    3'd3:             note_dur = 5'd4;
                    3'd4:             note_dur = 5'd16;
                    default:          note_dur = 5'd0;
                endcase
            end
            default: note_dur = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/sfx_sequencer_tone_gen.sv
// Square-wave generator: counts clocks up to the half-period and toggles.
// The tone output is the level the toggle flop holds in the next cycle, so
// the top can register it into the pin in step with busy.
module sfx_tone_gen
    import sfx_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [HALF_W-1:0] half_period,
    output logic              tone
);

    logic [HALF_W-1:0] r_cnt;
    logic              r_tone;
    logic [HALF_W-1:0] w_cnt_nxt;
    logic              w_tone_nxt;

    // Next counter/tone: restart or a rest clears both, else count and toggle.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_tone_nxt = r_tone;
        if (restart) begin
            w_cnt_nxt  = 16'd0;
            w_tone_nxt = 1'b0;
        end else if (half_period == 16'd0) begin
            w_cnt_nxt  = 16'd0;
            w_tone_nxt = 1'b0;
        end else if (r_cnt == (half_period - 16'd1)) begin
            w_cnt_nxt  = 16'd0;
            w_tone_nxt = ~r_tone;
        end else begin
            w_cnt_nxt  = r_cnt + 16'd1;
            w_tone_nxt = r_tone;
        end
    end

    // Half-period counter and toggle flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 16'd0;
            r_tone <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tone <= w_tone_nxt;
        end
    end

    assign tone = w_tone_nxt;

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: picks the highest-priority game event, plays its
// melody note by note (duration in game ticks, pitch from the tone generator)
// and drives a registered, mutable square wave on the audio pin.
module sfx_sequencer
    import sfx_sequencer_pkg::*;
#(
    parameter int unsigned PITCH_SHIFT  = 0,
    parameter bit          EN_MILESTONE = 1'b1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_tick,
    input  logic        jump_pulse,
    input  logic        game_over_pulse,
    input  logic        game_start_pulse,
    input  logic [15:0] score,
    input  logic        mute,
    output logic        sound,
    output logic        busy
);

    state_e            r_state;
    sfx_e              r_sfx;
    logic [NOTE_W-1:0] r_note_idx;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [15:0]       r_score_prev;
    logic              r_busy;
    logic              r_sound;

    state_e            w_state_nxt;
    sfx_e              w_sfx_nxt;
    logic [NOTE_W-1:0] w_note_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic              w_restart;
    sfx_e              w_req;
    logic              w_ms_req;
    logic              w_accept;
    logic [HALF_W-1:0] w_half_eff;
    logic [TICK_W-1:0] w_dur;
    logic              w_last;
    logic              w_tone_nxt;

    // A milestone is a change onto a whole hundred; a held score fires once.
    assign w_ms_req = EN_MILESTONE && (score != r_score_prev)
                      && (score[7:0] == 8'h00) && (score[15:8] != 8'h00);

    // Highest-priority request of this cycle.
    always_comb begin
        w_req = SFX_NONE;
        if (game_over_pulse) begin
            w_req = SFX_GAMEOVER;
        end else if (w_ms_req) begin
            w_req = SFX_MILESTONE;
        end else if (jump_pulse) begin
            w_req = SFX_JUMP;
        end else begin
            w_req = SFX_NONE;
        end
    end

    // Equal priority restarts; lower priority during play is dropped.
    assign w_accept   = (w_req != SFX_NONE) && ((r_state == ST_IDLE) || (w_req >= r_sfx));
    assign w_half_eff = note_half(r_sfx, r_note_idx) >> PITCH_SHIFT;
    assign w_dur      = note_dur(r_sfx, r_note_idx);
    assign w_last     = (r_note_idx == (note_count(r_sfx) - 3'd1));

    // Next state: accept beats game start, which beats the note advance.
    always_comb begin
        w_state_nxt = r_state;
        w_sfx_nxt   = r_sfx;
        w_note_nxt  = r_note_idx;
        w_tick_nxt  = r_tick_cnt;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_restart = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_PLAY;
                    w_sfx_nxt   = w_req;
                    w_note_nxt  = 3'd0;
                    w_tick_nxt  = 5'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (w_accept) begin
                    w_sfx_nxt  = w_req;
                    w_note_nxt = 3'd0;
                    w_tick_nxt = 5'd0;
                    w_restart  = 1'b1;
                end else if (game_start_pulse) begin
                    w_state_nxt = ST_IDLE;
                    w_sfx_nxt   = SFX_NONE;
                    w_note_nxt  = 3'd0;
                    w_tick_nxt  = 5'd0;
                    w_restart   = 1'b1;
                end else if (game_tick) begin
                    if (r_tick_cnt == (w_dur - 5'd1)) begin
                        w_tick_nxt = 5'd0;
                        w_restart  = 1'b1;
                        if (w_last) begin
                            w_state_nxt = ST_IDLE;
                            w_sfx_nxt   = SFX_NONE;
                            w_note_nxt  = 3'd0;
                        end else begin
                            w_note_nxt = r_note_idx + 3'd1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 5'd1;
                    end
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sfx_nxt   = SFX_NONE;
                w_note_nxt  = 3'd0;
                w_tick_nxt  = 5'd0;
                w_restart   = 1'b1;
            end
        endcase
    end

    sfx_tone_gen u_tone (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (w_restart),
        .half_period (w_half_eff),
        .tone        (w_tone_nxt)
    );

    // Sequencer registers plus the registered pin and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sfx        <= SFX_NONE;
            r_note_idx   <= 3'd0;
            r_tick_cnt   <= 5'd0;
            r_score_prev <= 16'd0;
            r_busy       <= 1'b0;
            r_sound      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sfx        <= w_sfx_nxt;
            r_note_idx   <= w_note_nxt;
            r_tick_cnt   <= w_tick_nxt;
            r_score_prev <= score;
            r_busy       <= (w_state_nxt == ST_PLAY);
            r_sound      <= w_tone_nxt & ~mute & (w_state_nxt == ST_PLAY);
        end
    end

    assign sound = r_sound;
    assign busy  = r_busy;

endmodule
